// File: rtl/numa_frame_sync.sv
// numa_frame_sync
// Byte-level frame synchroniser that sits in front of the NUMA payload parser.
// It hunts for the two-byte sync header in the raw UART byte stream and then
// checks the length byte and the 8-bit additive checksum. The payload is
// buffered, and only a validated payload is replayed as a contiguous burst.
//
// Frame format: SYNC0 SYNC1 LEN payload[0..LEN-1] CSUM
//   CSUM = (LEN + sum(payload)) mod 256
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx_data     received UART byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   data_out    validated payload byte; holds its value while data_valid is low
//   data_valid  data_out strobe, PAYLOAD_LEN consecutive cycles per good frame
//   frame_ok    pulse coincident with the last data_valid of a frame
//   frame_err   pulse one cycle after a rejected length, checksum or timeout
//   busy        high whenever the synchroniser is not in HUNT0
//   good_count  saturating count of delivered frames
//   err_count   saturating count of rejected frames
module numa_frame_sync #(
    parameter int unsigned PAYLOAD_LEN    = 12,
    parameter logic [7:0]  SYNC0          = 8'hB5,
    parameter logic [7:0]  SYNC1          = 8'h62,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [7:0]       data_out,
    output logic             data_valid,
    output logic             frame_ok,
    output logic             frame_err,
    output logic             busy,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned      IDX_W    = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       LEN_BYTE = 8'(PAYLOAD_LEN);

    localparam logic [2:0] ST_HUNT0   = 3'd0;
    localparam logic [2:0] ST_HUNT1   = 3'd1;
    localparam logic [2:0] ST_LEN     = 3'd2;
    localparam logic [2:0] ST_PAYLOAD = 3'd3;
    localparam logic [2:0] ST_CSUM    = 3'd4;
    localparam logic [2:0] ST_REPLAY  = 3'd5;

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_rd_idx;
    logic [7:0]       r_csum;
    logic [TO_W-1:0]  r_to;
    logic [7:0]       r_buf [PAYLOAD_LEN];
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_ok;
    logic             r_frame_err;
    logic [CNT_W-1:0] r_good_count;
    logic [CNT_W-1:0] r_err_count;

    logic w_timed;
    logic w_timeout;
    logic w_len_ok;
    logic w_csum_ok;
    logic w_err_evt;
    logic w_ok_evt;

    always_comb begin
        w_timed   = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
        // The timer counts idle cycles; the TIMEOUT_CYCLES-th idle cycle aborts.
        w_timeout = w_timed && !rx_valid && (r_to == TO_LAST);
        w_len_ok  = (rx_data == LEN_BYTE);
        w_csum_ok = (rx_data == r_csum);
        w_err_evt = w_timeout
                  || ((r_state == ST_LEN)  && rx_valid && !w_len_ok)
                  || ((r_state == ST_CSUM) && rx_valid && !w_csum_ok);
        // A one-byte payload finishes its replay in the cycle right after CSUM.
        w_ok_evt  = ((r_state == ST_CSUM) && rx_valid && w_csum_ok && (PAYLOAD_LEN == 1))
                  || ((r_state == ST_REPLAY) && (r_rd_idx == LAST_IDX));
    end

    // Payload storage needs no reset: it is only read after a full frame is written.
    always_ff @(posedge clk) begin
        if ((r_state == ST_PAYLOAD) && rx_valid) begin
            r_buf[r_wr_idx] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT0;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_csum       <= '0;
            r_to         <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_good_count <= '0;
            r_err_count  <= '0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_ok   <= w_ok_evt;
            r_frame_err  <= w_err_evt;

            if (w_ok_evt && (r_good_count != {CNT_W{1'b1}})) begin
                r_good_count <= r_good_count + 1'b1;
            end
            if (w_err_evt && (r_err_count != {CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end

            if (rx_valid || !w_timed || w_timeout) begin
                r_to <= '0;
            end else begin
                r_to <= r_to + 1'b1;
            end

            case (r_state)
                ST_HUNT0: begin
                    if (rx_valid && (rx_data == SYNC0)) begin
                        r_state <= ST_HUNT1;
                    end
                end
                ST_HUNT1: begin
                    if (rx_valid) begin
                        if (rx_data == SYNC1) begin
                            r_state <= ST_LEN;
                        end else if (rx_data != SYNC0) begin
                            r_state <= ST_HUNT0;
                        end
                    end
                end
                ST_LEN: begin
                    if (w_timeout) begin
                        r_state <= ST_HUNT0;
                    end else if (rx_valid) begin
                        if (w_len_ok) begin
                            r_csum   <= rx_data;
                            r_wr_idx <= '0;
                            r_state  <= ST_PAYLOAD;
                        end else begin
                            r_state <= ST_HUNT0;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (w_timeout) begin
                        r_state <= ST_HUNT0;
                    end else if (rx_valid) begin
                        r_csum <= r_csum + rx_data;
                        if (r_wr_idx == LAST_IDX) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_wr_idx <= r_wr_idx + 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_timeout) begin
                        r_state <= ST_HUNT0;
                    end else if (rx_valid) begin
                        if (w_csum_ok) begin
                            r_data_out   <= r_buf[0];
                            r_data_valid <= 1'b1;
                            r_rd_idx     <= IDX_W'(1);
                            r_state      <= (PAYLOAD_LEN == 1) ? ST_HUNT0 : ST_REPLAY;
                        end else begin
                            r_state <= ST_HUNT0;
                        end
                    end
                end
                ST_REPLAY: begin
                    // rx bytes are ignored here; the last byte is issued while
                    // returning to HUNT0 so the burst stays contiguous.
                    r_data_out   <= r_buf[r_rd_idx];
                    r_data_valid <= 1'b1;
                    r_rd_idx     <= r_rd_idx + 1'b1;
                    if (r_rd_idx == LAST_IDX) begin
                        r_state <= ST_HUNT0;
                    end
                end
                default: r_state <= ST_HUNT0;
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_ok   = r_frame_ok;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state != ST_HUNT0);
    assign good_count = r_good_count;
    assign err_count  = r_err_count;

endmodule

// File: doc/numa_frame_sync.md
Name: numa_frame_sync

Overview:
Byte-level frame synchroniser directly upstream of the NUMA payload parser. It hunts for the two-byte sync header in the raw UART receive stream and checks the length byte and the 8-bit checksum. It buffers the payload internally and replays only validated payloads as a contiguous burst on data_out/data_valid. The parser therefore never sees partial, misaligned or corrupt frames.

Parameters:
PAYLOAD_LEN, 12, payload bytes per frame; the only legal LEN value; range 1..255
SYNC0, 8'hB5, first sync byte
SYNC1, 8'h62, second sync byte
TIMEOUT_CYCLES, 100000, maximum idle clk cycles between bytes inside a frame
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte from UART
rx_valid  in  1  one-cycle strobe; rx_data valid
data_out  out  8  validated payload byte to parser
data_valid  out  1  data_out valid strobe
frame_ok  out  1  one-cycle pulse: frame delivered
frame_err  out  1  one-cycle pulse: frame rejected
busy  out  1  high in every state except HUNT0
good_count  out  CNT_W  frames delivered, saturating
err_count  out  CNT_W  frames rejected, saturating

Behaviour:
- Reset (sync, active-high): state HUNT0; data_out=0, data_valid=0, frame_ok=0, frame_err=0, busy=0, good_count=0, err_count=0; timeout counter, checksum and write index cleared. Reset mid-frame or mid-replay aborts immediately; no further data_valid is asserted.
- States: HUNT0, HUNT1, LEN, PAYLOAD, CSUM, REPLAY.
- HUNT0: on rx_valid with byte==SYNC0, go to HUNT1. Any other byte is discarded silently and does not count as an error.
- HUNT1: on rx_valid, byte==SYNC1 goes to LEN. Byte==SYNC0 stays in HUNT1 (resync). Any other byte returns to HUNT0 with no error.
- LEN: on rx_valid, byte==PAYLOAD_LEN initialises csum=byte and idx=0, then goes to PAYLOAD. Otherwise frame_err pulses and the block returns to HUNT0.
- PAYLOAD: each rx_valid stores the byte at buf[idx], sets csum=csum+byte (mod 256) and increments idx. After the PAYLOAD_LEN-th byte, go to CSUM.
- CSUM: on rx_valid, byte==csum goes to REPLAY. On mismatch, frame_err pulses and the block returns to HUNT0. No payload byte is emitted for a rejected frame.
- REPLAY: data_valid=1 for exactly PAYLOAD_LEN consecutive cycles, with data_out=buf[0..PAYLOAD_LEN-1] in order. The first data_valid is the cycle after the checksum byte is accepted. frame_ok is asserted in the same cycle as the last data_valid. good_count increments, and the block returns to HUNT0.
- rx_valid during REPLAY is dropped (not buffered, not counted). Sync bytes arriving during REPLAY are lost.
- Timeout: in LEN, PAYLOAD and CSUM, a counter increments each cycle without rx_valid and clears on rx_valid. Reaching TIMEOUT_CYCLES pulses frame_err and returns to HUNT0. The counter is not active in HUNT0, HUNT1 or REPLAY.
- frame_err is asserted the cycle after the offending byte or the timeout event. err_count increments on every frame_err.
- Counters saturate at all-ones and do not wrap.
- data_out holds its last value when data_valid=0.

Test Plan:
- Clean frame: B5 62 0C, payload 01..0C, checksum 5A → 12 consecutive data_valid with bytes 01..0C; frame_ok on the 12th; good_count=1, err_count=0.
- Bad checksum: same frame with checksum 5B → no data_valid; one frame_err pulse; err_count=1; the next clean frame is delivered normally.
- Resync/noise: FF B5 B5 62 0C + valid payload/checksum → frame delivered; leading FF and duplicate B5 cause no error.
- Wrong length: B5 62 0B → frame_err; err_count=1; state returns to HUNT0 (busy=0).
- Timeout (TIMEOUT_CYCLES=50): B5 62 0C 01 02, then idle for 50 cycles → frame_err pulse; a following clean frame is delivered.
- Reset mid-replay: assert rst during the 5th data_valid → all outputs 0 the next cycle; no further data_valid; counters=0.
